// File: rtl/ar_fifo_gearbox_down.sv
// rtl/ar_fifo_gearbox_down.sv - wide-to-narrow FIFO gearbox with end-of-message and partial final word
//
// Drains wide words from a registered SRL FIFO (EMPTY_N/DEQ/D_IN) and emits
// them LSB lane first into an ENQ/FULL_N sink, one lane per clock, with no
// bubble between consecutive words.
//
// Ports:
//   CLK      clock, all state on rising edge
//   RST_N    asynchronous active-low reset
//   CLR      synchronous clear, drops the held word
//   EMPTY_N  upstream word available
//   D_IN     upstream word, lane k = D_IN[k*owidth +: owidth]
//   EOM_IN   upstream word ends a message
//   NLANES   valid lanes in an EOM word (0 = all lanes)
//   DEQ      consume upstream word this cycle (combinational)
//   FULL_N   downstream can accept a lane
//   ENQ      lane on D_OUT transfers this cycle (combinational)
//   D_OUT    current lane
//   EOM_OUT  current lane is the last of a message
module ar_fifo_gearbox_down #(
  parameter int owidth  = 32,
  parameter int l2ratio = 2
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  input  logic                               CLR,
  input  logic                               EMPTY_N,
  input  logic [owidth*(1<<l2ratio)-1:0]     D_IN,
  input  logic                               EOM_IN,
  input  logic [l2ratio-1:0]                 NLANES,
  output logic                               DEQ,
  input  logic                               FULL_N,
  output logic                               ENQ,
  output logic [owidth-1:0]                  D_OUT,
  output logic                               EOM_OUT
);

  localparam int ratio  = 1 << l2ratio;
  localparam int iwidth = owidth * ratio;
  localparam logic [l2ratio-1:0] last_full = l2ratio'(ratio - 1);

  logic [iwidth-1:0]  hreg;
  logic               hvalid;
  logic [l2ratio-1:0] lane;
  logic [l2ratio-1:0] last_idx;
  logic               heom;
  logic               at_last;

  assign at_last = (lane == last_idx);

  // RST_N gates the control outputs so they drop the instant reset is
  // applied; otherwise an empty hold would request DEQ during reset.
  assign ENQ     = RST_N && hvalid && FULL_N && !CLR;
  assign DEQ     = RST_N && EMPTY_N && !CLR && (!hvalid || (ENQ && at_last));
  assign D_OUT   = hreg[lane*owidth +: owidth];
  assign EOM_OUT = hvalid && heom && at_last;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hreg     <= '0;
      hvalid   <= 1'b0;
      lane     <= '0;
      heom     <= 1'b0;
      last_idx <= last_full;
    end else if (CLR) begin
      hvalid   <= 1'b0;
      lane     <= '0;
      heom     <= 1'b0;
      last_idx <= last_full;
    end else if (DEQ) begin
      // Covers both an empty hold and the back-to-back reload on the last lane.
      hreg     <= D_IN;
      hvalid   <= 1'b1;
      lane     <= '0;
      heom     <= EOM_IN;
      last_idx <= (EOM_IN && NLANES != '0) ? NLANES - l2ratio'(1) : last_full;
    end else if (ENQ) begin
      if (!at_last) begin
        lane <= lane + l2ratio'(1);
      end else begin
        hvalid <= 1'b0;
        lane   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ar_fifo_gearbox_down.sv
// tb/tb_ar_fifo_gearbox_down.sv - randomized self-checking bench for ar_fifo_gearbox_down
module tb_ar_fifo_gearbox_down;

  localparam int OW = 32;
  localparam int L2 = 2;
  localparam int NL = 1 << L2;
  localparam int IW = OW * NL;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          CLR = 1'b0;
  logic          EMPTY_N = 1'b0;
  logic [IW-1:0] D_IN = '0;
  logic          EOM_IN = 1'b0;
  logic [L2-1:0] NLANES = '0;
  logic          DEQ;
  logic          FULL_N = 1'b0;
  logic          ENQ;
  logic [OW-1:0] D_OUT;
  logic          EOM_OUT;

  ar_fifo_gearbox_down #(.owidth(OW), .l2ratio(L2)) dut (
    .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .EMPTY_N(EMPTY_N), .D_IN(D_IN),
    .EOM_IN(EOM_IN), .NLANES(NLANES), .DEQ(DEQ), .FULL_N(FULL_N),
    .ENQ(ENQ), .D_OUT(D_OUT), .EOM_OUT(EOM_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [IW-1:0] d; logic eom; logic [L2-1:0] nl; } word_t;
  typedef struct { logic [OW-1:0] d; logic eom; } lane_t;

  word_t src_q[$];   // words waiting upstream
  lane_t exp_q[$];   // lanes still owed by the word currently held
  int    vectors = 0;
  int    miscompares = 0;
  bit    e_enq, e_deq, e_clr;
  lane_t e_lane;

  function automatic logic [IW-1:0] rand_wide();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic word_t rand_word();
    word_t w;
    w.d   = rand_wide();
    w.eom = ($urandom % 3) == 0;
    w.nl  = L2'($urandom);
    return w;
  endfunction

  // A word becomes its list of emitted lanes: NLANES lanes for an EOM word
  // with NLANES != 0, otherwise every lane; EOM marks only the final one.
  function automatic void push_lanes(word_t w);
    int n;
    lane_t l;
    n = (w.eom && w.nl != 0) ? int'(w.nl) : NL;
    for (int k = 0; k < n; k++) begin
      l.d   = w.d[k*OW +: OW];
      l.eom = w.eom && (k == n - 1);
      exp_q.push_back(l);
    end
  endfunction

  // Drive one cycle's inputs and work out what the sink/source should see:
  // a lane moves whenever one is owed and the sink has room; a new word is
  // taken whenever one is offered and the hold is empty or finishing now.
  task automatic present(input bit en, input bit fn, input bit clr);
    word_t w;
    EMPTY_N = en && (src_q.size() > 0);
    if (EMPTY_N) begin
      w = src_q[0];
      D_IN = w.d; EOM_IN = w.eom; NLANES = w.nl;
    end else begin
      D_IN = rand_wide(); EOM_IN = 1'($urandom); NLANES = L2'($urandom);
    end
    FULL_N = fn; CLR = clr; e_clr = clr;
    e_enq = !clr && fn && (exp_q.size() > 0);
    e_deq = !clr && EMPTY_N && (exp_q.size() == 0 || (exp_q.size() == 1 && e_enq));
    if (e_enq) e_lane = exp_q[0];
    else e_lane = '{d: '0, eom: 1'b0};
  endtask

  task automatic apply(input bit en, input bit fn, input bit clr);
    @(posedge CLK); #1;
    present(en, fn, clr);
    #4;
  endtask

  task automatic commit();
    if (e_clr) begin
      exp_q.delete();
    end else begin
      if (e_enq) void'(exp_q.pop_front());
      if (e_deq) push_lanes(src_q.pop_front());
    end
  endtask

  task automatic sync_clear();
    apply(0, 1, 1);
    commit();
    src_q.delete();
  endtask

  task automatic test_reset();
    EMPTY_N = 1'b1; FULL_N = 1'b1; D_IN = rand_wide();
    #3;
    vectors++; if (DEQ !== 1'b0) begin miscompares++; $display("FAIL reset_deq got %b want 0", DEQ); end
    vectors++; if (ENQ !== 1'b0) begin miscompares++; $display("FAIL reset_enq got %b want 0", ENQ); end
    vectors++; if (EOM_OUT !== 1'b0) begin miscompares++; $display("FAIL reset_eom got %b want 0", EOM_OUT); end
    vectors++; if (D_OUT !== '0) begin miscompares++; $display("FAIL reset_dout got %h want 0", D_OUT); end
    @(negedge CLK); RST_N = 1'b1; EMPTY_N = 1'b0;
    exp_q.delete(); src_q.delete();
  endtask

  task automatic test_streaming();
    word_t w;
    int ndeq = 0, nenq = 0;
    w.eom = 1'b0; w.nl = '0;
    w.d = 128'h44444444_33333333_22222222_11111111; src_q.push_back(w);
    w.d = 128'h88888888_77777777_66666666_55555555; src_q.push_back(w);
    for (int i = 0; i < 10; i++) begin
      apply(1, 1, 0);
      ndeq += int'(DEQ); nenq += int'(ENQ);
      vectors++; if (DEQ !== e_deq) begin miscompares++; $display("FAIL stream_deq cyc %0d got %b want %b", i, DEQ, e_deq); end
      vectors++; if (ENQ !== e_enq) begin miscompares++; $display("FAIL stream_enq cyc %0d got %b want %b", i, ENQ, e_enq); end
      if (e_enq) begin
        vectors++;
        if (D_OUT !== e_lane.d || EOM_OUT !== e_lane.eom) begin
          miscompares++; $display("FAIL stream_lane cyc %0d got %h/%b want %h/%b", i, D_OUT, EOM_OUT, e_lane.d, e_lane.eom);
        end
      end
      commit();
    end
    vectors++; if (ndeq != 2) begin miscompares++; $display("FAIL stream_deq_count got %0d want 2", ndeq); end
    vectors++; if (nenq != 8) begin miscompares++; $display("FAIL stream_enq_count got %0d want 8", nenq); end
    sync_clear();
  endtask

  task automatic test_partial_eom();
    word_t w;
    int neom = 0, nenq = 0;
    w.d = rand_wide(); w.eom = 1'b1; w.nl = 2'd3; src_q.push_back(w);
    w.d = rand_wide(); w.eom = 1'b1; w.nl = 2'd0; src_q.push_back(w);
    w.d = rand_wide(); w.eom = 1'b0; w.nl = 2'd2; src_q.push_back(w);
    for (int i = 0; i < 14; i++) begin
      apply(1, 1, 0);
      nenq += int'(ENQ); neom += int'(ENQ && EOM_OUT);
      vectors++; if (DEQ !== e_deq) begin miscompares++; $display("FAIL eom_deq cyc %0d got %b want %b", i, DEQ, e_deq); end
      vectors++; if (ENQ !== e_enq) begin miscompares++; $display("FAIL eom_enq cyc %0d got %b want %b", i, ENQ, e_enq); end
      if (e_enq) begin
        vectors++;
        if (D_OUT !== e_lane.d || EOM_OUT !== e_lane.eom) begin
          miscompares++; $display("FAIL eom_lane cyc %0d got %h/%b want %h/%b", i, D_OUT, EOM_OUT, e_lane.d, e_lane.eom);
        end
      end
      commit();
    end
    vectors++; if (nenq != 11) begin miscompares++; $display("FAIL eom_enq_count got %0d want 11", nenq); end
    vectors++; if (neom != 2) begin miscompares++; $display("FAIL eom_marker_count got %0d want 2", neom); end
    sync_clear();
  endtask

  task automatic test_backpressure();
    bit fpat [12] = '{1, 0, 0, 1, 0, 1, 1, 0, 1, 1, 0, 1};
    bit fn;
    src_q.push_back(rand_word()); src_q[0].eom = 1'b0;
    src_q.push_back(rand_word()); src_q[1].eom = 1'b0;
    for (int i = 0; i < 20; i++) begin
      fn = (i < 12) ? fpat[i] : 1'b1;
      apply(1, fn, 0);
      vectors++; if (DEQ !== e_deq) begin miscompares++; $display("FAIL bp_deq cyc %0d got %b want %b", i, DEQ, e_deq); end
      vectors++; if (ENQ !== e_enq) begin miscompares++; $display("FAIL bp_enq cyc %0d got %b want %b", i, ENQ, e_enq); end
      if (exp_q.size() > 0) begin
        vectors++;
        if (D_OUT !== exp_q[0].d) begin
          miscompares++; $display("FAIL bp_lane cyc %0d got %h want %h", i, D_OUT, exp_q[0].d);
        end
      end
      commit();
    end
    vectors++; if (exp_q.size() != 0 || src_q.size() != 0) begin
      miscompares++; $display("FAIL bp_drain got %0d/%0d want 0/0 lanes/words left", exp_q.size(), src_q.size());
    end
    sync_clear();
  endtask

  task automatic test_starvation();
    src_q.push_back(rand_word()); src_q.push_back(rand_word());
    for (int i = 0; i < 18; i++) begin
      apply(i == 0 || i >= 10, 1, 0);
      vectors++; if (DEQ !== e_deq) begin miscompares++; $display("FAIL starve_deq cyc %0d got %b want %b", i, DEQ, e_deq); end
      vectors++; if (ENQ !== e_enq) begin miscompares++; $display("FAIL starve_enq cyc %0d got %b want %b", i, ENQ, e_enq); end
      if (e_enq) begin
        vectors++;
        if (D_OUT !== e_lane.d || EOM_OUT !== e_lane.eom) begin
          miscompares++; $display("FAIL starve_lane cyc %0d got %h/%b want %h/%b", i, D_OUT, EOM_OUT, e_lane.d, e_lane.eom);
        end
      end
      commit();
    end
    sync_clear();
  endtask

  task automatic test_clr_mid_word();
    word_t w;
    w.d = rand_wide(); w.eom = 1'b1; w.nl = 2'd3; src_q.push_back(w);
    src_q.push_back(rand_word());
    for (int i = 0; i < 10; i++) begin
      apply(1, 1, i == 3);
      vectors++; if (DEQ !== e_deq) begin miscompares++; $display("FAIL clr_deq cyc %0d got %b want %b", i, DEQ, e_deq); end
      vectors++; if (ENQ !== e_enq) begin miscompares++; $display("FAIL clr_enq cyc %0d got %b want %b", i, ENQ, e_enq); end
      if (e_enq) begin
        vectors++;
        if (D_OUT !== e_lane.d || EOM_OUT !== e_lane.eom) begin
          miscompares++; $display("FAIL clr_lane cyc %0d got %h/%b want %h/%b", i, D_OUT, EOM_OUT, e_lane.d, e_lane.eom);
        end
      end
      commit();
    end
    sync_clear();
  endtask

  task automatic test_async_reset();
    word_t w;
    w.d = rand_wide(); w.eom = 1'b1; w.nl = 2'd2; src_q.push_back(w);
    src_q.push_back(rand_word());
    apply(1, 1, 0); commit();
    apply(1, 1, 0); commit();
    @(posedge CLK); #1;
    present(1, 1, 0);
    #1;
    vectors++; if (EOM_OUT !== 1'b1 || ENQ !== 1'b1) begin
      miscompares++; $display("FAIL arst_pre got %b/%b want 1/1 eom/enq", EOM_OUT, ENQ);
    end
    RST_N = 1'b0;
    #1;
    vectors++; if (DEQ !== 1'b0) begin miscompares++; $display("FAIL arst_deq got %b want 0", DEQ); end
    vectors++; if (ENQ !== 1'b0) begin miscompares++; $display("FAIL arst_enq got %b want 0", ENQ); end
    vectors++; if (EOM_OUT !== 1'b0) begin miscompares++; $display("FAIL arst_eom got %b want 0", EOM_OUT); end
    vectors++; if (D_OUT !== '0) begin miscompares++; $display("FAIL arst_dout got %h want 0", D_OUT); end
    exp_q.delete();
    @(posedge CLK); #1;
    present(1, 1, 0);
    #2; RST_N = 1'b1; #2;
    vectors++; if (DEQ !== e_deq) begin miscompares++; $display("FAIL arst_release_deq got %b want %b", DEQ, e_deq); end
    commit();
    for (int i = 0; i < 6; i++) begin
      apply(1, 1, 0);
      vectors++; if (ENQ !== e_enq) begin miscompares++; $display("FAIL arst_enq_after cyc %0d got %b want %b", i, ENQ, e_enq); end
      if (e_enq) begin
        vectors++;
        if (D_OUT !== e_lane.d || EOM_OUT !== e_lane.eom) begin
          miscompares++; $display("FAIL arst_lane cyc %0d got %h/%b want %h/%b", i, D_OUT, EOM_OUT, e_lane.d, e_lane.eom);
        end
      end
      commit();
    end
    sync_clear();
  endtask

  task automatic test_random_traffic();
    for (int i = 0; i < 400; i++) begin
      while (src_q.size() < 2) src_q.push_back(rand_word());
      apply(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 60) == 0);
      vectors++; if (DEQ !== e_deq) begin miscompares++; $display("FAIL rand_deq cyc %0d got %b want %b", i, DEQ, e_deq); end
      vectors++; if (ENQ !== e_enq) begin miscompares++; $display("FAIL rand_enq cyc %0d got %b want %b", i, ENQ, e_enq); end
      if (e_enq) begin
        vectors++;
        if (D_OUT !== e_lane.d || EOM_OUT !== e_lane.eom) begin
          miscompares++; $display("FAIL rand_lane cyc %0d got %h/%b want %h/%b", i, D_OUT, EOM_OUT, e_lane.d, e_lane.eom);
        end
      end
      commit();
    end
    sync_clear();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_partial_eom();
    test_backpressure();
    test_starvation();
    test_clr_mid_word();
    test_async_reset();
    test_random_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
